fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch front end for the Primitive-RISC-V core. It owns the PC, issues single-outstanding requests to instruction memory and holds the returned word. It presents the op/funct3/funct7b5 fields to the control unit and consumes that unit's pcsrc, together with the datapath branch target, to choose the next PC. Sits between instruction memory and the control unit/datapath.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
imem_req  out  1  one-cycle fetch request strobe
imem_addr  out  32  fetch address, valid when imem_req=1, bits [1:0] always 0
imem_rvalid  in  1  response strobe; exactly one per accepted request, ≥1 cycle after it
imem_rdata  in  32  instruction word, valid when imem_rvalid=1
stall  in  1  consumer not ready; holds the current instruction
pcsrc  in  1  take pctarget for the next fetch (from control unit)
pctarget  in  32  branch/jump target from datapath
instr_valid  out  1  instr/pc fields hold a valid instruction
instr  out  32  held instruction word
op  out  7  instr[6:0]
funct3  out  3  instr[14:12]
funct7b5  out  1  instr[30]
pc  out  32  address of held instruction
pcplus4  out  32  pc + 4, modulo 2^32
instret  out  CNT_W  retired-instruction count
proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset. On any clock edge with reset=1: state=REQ, pc=RESET_PC, instr=32'h0000_0013 (NOP), instr_valid=0, instret=0, proto_err=0. imem_req=0 while reset=1. Instruction memory is reset by the same reset, so no response survives a reset.
- FSM states: REQ, WAIT, VALID.
- REQ: imem_req=1, imem_addr=pc. Go to WAIT unconditionally.
- WAIT: imem_req=0. When imem_rvalid=1: register instr<=imem_rdata, go to VALID. Otherwise stay.
- VALID: instr_valid=1.
  - A consume occurs when stall=0.
  - On consume: nextpc = pcsrc ? {pctarget[31:2],2'b00} : pc+4.
  - In the same cycle, drive imem_req=1 and imem_addr=nextpc (combinational).
  - At the edge: pc<=nextpc, instret<=instret+1 (wraps modulo 2^CNT_W), go to WAIT.
  - With stall=1: instr, pc and instret hold; imem_req=0; pcsrc and pctarget are ignored.
- pcsrc and pctarget are sampled only on a consume cycle; in REQ and WAIT they are don't-care.
- Throughput: 2 cycles per instruction with a 1-cycle-latency memory (VALID+req, WAIT+rvalid). First instr_valid is 3 cycles after reset deasserts: REQ, WAIT, VALID.
- pc+4 wraps 32'hFFFF_FFFC to 32'h0000_0000 with no error.
- pctarget[1:0] are silently cleared. No misalignment trap in this version.
- instr_valid=0 in REQ/WAIT. op/funct3/funct7b5/pc keep the last registered values; consumers must qualify with instr_valid.
- proto_err is set (sticky until reset) when imem_rvalid=1 in REQ or VALID. That response is discarded: the held instr and state are unchanged.
- Output timing: all outputs except imem_req/imem_addr are registered or pure slices of registers. imem_req/imem_addr are combinational from state, pc, stall, pcsrc and pctarget.

Test Plan:
- Reset release, RESET_PC=0, memory returns rdata=addr|0x13 after 1 cycle → imem_req at cycle 0 with addr 0; instr_valid=1 at cycle 2 with instr=0x13 and pc=0. With stall=0, addresses 0,4,8,12 are requested every 2 cycles; instret=4 after the 4th consume.
- stall=1 for 5 cycles while VALID with pc=8 → no imem_req, instr/pc/instret stable. On the stall=0 cycle, imem_req=1 with addr=12.
- Consume at pc=0x10 with pcsrc=1 and pctarget=0x103 → imem_addr=0x100; next pc=0x100, pcplus4=0x104. With pcsrc=1 during WAIT, no effect.
- Memory latency of 4 cycles → remains in WAIT with instr_valid=0, no extra requests. Then imem_rvalid pulse → VALID.
- Spurious imem_rvalid in VALID with rdata=0xDEADBEEF → proto_err=1 and stays 1, instr unchanged. Also set when imem_rvalid arrives in REQ.
- Reset asserted mid-WAIT at pc=0x40 → next cycle pc=RESET_PC, instr_valid=0, instret=0, proto_err=0; fresh request to RESET_PC after release.
- CNT_W=4, 17 consumes → instret=1 (wrap). PC at 0xFFFFFFFC consumed with pcsrc=0 → next fetch address 0x0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end.
// Owns the PC, issues single-outstanding requests to instruction memory,
// holds the returned word and exposes its decode fields to the control unit.
//
// Ports:
//   clk, reset                 clock / synchronous active-high reset
//   imem_req, imem_addr        fetch request strobe and word address (comb.)
//   imem_rvalid, imem_rdata    memory response strobe and instruction word
//   stall                      consumer not ready; hold current instruction
//   pcsrc, pctarget            redirect select and target, sampled on consume
//   instr_valid, instr         held instruction and its qualifier
//   op, funct3, funct7b5       decode fields sliced from instr
//   pc, pcplus4                address of held instruction and pc + 4
//   instret                    retired-instruction counter (wraps)
//   proto_err                  sticky flag: response arrived with none pending
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  input  logic             stall,
  input  logic             pcsrc,
  input  logic [31:0]      pctarget,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [6:0]       op,
  output logic [2:0]       funct3,
  output logic             funct7b5,
  output logic [31:0]      pc,
  output logic [31:0]      pcplus4,
  output logic [CNT_W-1:0] instret,
  output logic             proto_err
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_VALID
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             err_q, err_d;
  logic [31:0]      nextpc;

  // Redirect target is forced to word alignment; low bits are dropped silently.
  assign nextpc = pcsrc ? (pctarget & ~32'd3) : (pc_q + 32'd4);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      instr_q   <= NOP;
      instret_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    err_d     = err_q;
    imem_req  = 1'b0;
    imem_addr = pc_q;
    unique case (state_q)
      S_REQ: begin
        imem_req = 1'b1;
        state_d  = S_WAIT;
        if (imem_rvalid) err_d = 1'b1;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        // A response here has no request behind it: flag it and drop the data.
        if (imem_rvalid) err_d = 1'b1;
        if (!stall) begin
          imem_req  = 1'b1;
          imem_addr = nextpc;
          pc_d      = nextpc;
          instret_d = instret_q + CNT_W'(1);
          state_d   = S_WAIT;
        end
      end
      default: state_d = S_REQ;
    endcase
    // Memory shares our reset, so nothing may be requested while it is held.
    if (reset) imem_req = 1'b0;
  end

  assign instr_valid = (state_q == S_VALID);
  assign instr       = instr_q;
  assign op          = instr_q[6:0];
  assign funct3      = instr_q[14:12];
  assign funct7b5    = instr_q[30];
  assign pc          = pc_q;
  assign pcplus4     = pc_q + 32'd4;
  assign instret     = instret_q;
  assign proto_err   = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit (CNT_W=4, RESET_PC=0).
// A transaction-level reference model tracks which instruction is held,
// whether a fetch is outstanding, the PC, retire count and error flag.
module tb_fetch_unit;

  localparam int unsigned CNT_W    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic             clk = 1'b0;
  logic             reset;
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic             imem_rvalid;
  logic [31:0]      imem_rdata;
  logic             stall;
  logic             pcsrc;
  logic [31:0]      pctarget;
  logic             instr_valid;
  logic [31:0]      instr;
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic             funct7b5;
  logic [31:0]      pc;
  logic [31:0]      pcplus4;
  logic [CNT_W-1:0] instret;
  logic             proto_err;

  fetch_unit #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .pcsrc(pcsrc), .pctarget(pctarget),
    .instr_valid(instr_valid), .instr(instr), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .pc(pc), .pcplus4(pcplus4),
    .instret(instret), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // reference model
  bit          m_fresh;    // a fetch of m_pc must be issued this cycle
  bit          m_valid;    // an instruction is held
  bit          m_out;      // a fetch is outstanding
  bit          m_err;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  int unsigned m_instret;

  // memory model
  bit          mem_pend;
  int unsigned mem_due;
  logic [31:0] mem_addr;
  int unsigned lat = 1;
  int unsigned cyc = 0;
  bit          spur = 0;
  logic [31:0] spur_data = 32'hDEAD_BEEF;

  logic [31:0] last_addr;
  logic        last_req;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fresh = 1; m_valid = 0; m_out = 0; m_err = 0;
    m_pc = RESET_PC; m_instr = 32'h0000_0013; m_instret = 0;
    mem_pend = 0;
  endtask

  task automatic step(input logic st, input logic ps, input logic [31:0] tg);
    logic [31:0] nxt;
    logic [31:0] eaddr;
    logic        ereq;
    stall = st; pcsrc = ps; pctarget = tg;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (!reset && mem_pend && cyc == mem_due) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_addr | 32'h13;
      mem_pend    = 0;
    end else if (!reset && spur) begin
      imem_rvalid = 1'b1;
      imem_rdata  = spur_data;
      spur        = 0;
    end
    #2;
    nxt   = ps ? {tg[31:2], 2'b00} : m_pc + 32'd4;
    ereq  = !reset && (m_fresh || (m_valid && !st));
    eaddr = m_fresh ? m_pc : nxt;
    chk("imem_req", {31'b0, imem_req}, {31'b0, ereq});
    if (ereq) chk("imem_addr", imem_addr, eaddr);
    last_addr = imem_addr;
    last_req  = imem_req;
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
    chk("pc", pc, m_pc);
    chk("pcplus4", pcplus4, m_pc + 32'd4);
    chk("instr", instr, m_instr);
    chk("op", {25'b0, op}, {25'b0, m_instr[6:0]});
    chk("funct3", {29'b0, funct3}, {29'b0, m_instr[14:12]});
    chk("funct7b5", {31'b0, funct7b5}, {31'b0, m_instr[30]});
    chk("instret", {28'b0, instret}, m_instret % (1 << CNT_W));
    chk("proto_err", {31'b0, proto_err}, {31'b0, m_err});
    if (ereq) begin
      mem_pend = 1; mem_addr = eaddr; mem_due = cyc + lat;
    end
    if (reset) begin
      model_reset();
    end else begin
      if (imem_rvalid && !m_out) m_err = 1;
      if (m_fresh) begin
        m_fresh = 0; m_out = 1;
      end else if (m_valid && !st) begin
        m_pc = nxt; m_instret++; m_valid = 0; m_out = 1;
      end else if (m_out && imem_rvalid) begin
        m_instr = imem_rdata; m_valid = 1; m_out = 0;
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset(input int unsigned n);
    reset = 1'b1;
    repeat (n) step(1'b0, 1'b0, 32'h0);
    reset = 1'b0;
  endtask

  // stall/pcsrc/pctarget are randomised while waiting; they must not matter
  task automatic wait_valid();
    int unsigned n = 0;
    while (!m_valid && n < 30) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      n++;
    end
    chk("valid_reached", {31'b0, instr_valid}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; pcsrc = 1'b0; pctarget = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    @(posedge clk); #1;
    model_reset();
    do_reset(2);

    // sequential fetch 0,4,8 then stall at pc=8
    wait_valid(); chk("first_pc", pc, 32'h0); chk("first_instr", instr, 32'h13);
    step(1'b0, 1'b0, 32'h0);
    wait_valid(); step(1'b0, 1'b0, 32'h0);
    wait_valid(); chk("stall_pc", pc, 32'h8);
    repeat (5) step(1'b1, 1'b1, $urandom);
    step(1'b0, 1'b0, 32'h0);
    chk("after_stall_req", {31'b0, last_req}, 32'd1);
    chk("after_stall_addr", last_addr, 32'hC);
    wait_valid(); step(1'b0, 1'b0, 32'h0);
    chk("instret4", {28'b0, instret}, 32'd4);

    // redirect at pc=0x10
    wait_valid(); chk("br_pc", pc, 32'h10);
    step(1'b0, 1'b1, 32'h103);
    chk("br_addr", last_addr, 32'h100);
    wait_valid(); chk("br_newpc", pc, 32'h100); chk("br_pcplus4", pcplus4, 32'h104);

    // 4-cycle memory latency
    lat = 4;
    step(1'b0, 1'b0, 32'h0);
    wait_valid();
    lat = 1;

    // spurious response while holding an instruction
    spur = 1; spur_data = 32'hDEAD_BEEF;
    step(1'b1, 1'b0, 32'h0);
    chk("err_valid", {31'b0, proto_err}, 32'd1);
    repeat (3) step(1'b1, 1'b0, 32'h0);
    chk("err_sticky", {31'b0, proto_err}, 32'd1);

    // reset while waiting on a fetch of 0x40
    lat = 4;
    step(1'b0, 1'b1, 32'h40);
    step(1'b0, 1'b0, 32'h0);
    chk("midwait_pc", pc, 32'h40);
    do_reset(1);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_instret", {28'b0, instret}, 32'd0);
    chk("rst_err", {31'b0, proto_err}, 32'd0);
    step(1'b0, 1'b0, 32'h0);
    chk("rst_refetch", last_addr, RESET_PC);
    lat = 1;

    // spurious response in the request cycle
    do_reset(1);
    spur = 1; spur_data = 32'hDEAD_BEEF;
    step(1'b0, 1'b0, 32'h0);
    chk("err_req", {31'b0, proto_err}, 32'd1);
    wait_valid();

    // PC wrap at the top of the address space
    do_reset(1);
    wait_valid(); step(1'b0, 1'b1, 32'hFFFF_FFFF);
    chk("top_addr", last_addr, 32'hFFFF_FFFC);
    wait_valid(); step(1'b0, 1'b0, 32'h0);
    chk("wrap_addr", last_addr, 32'h0);

    // retire counter wrap
    do_reset(1);
    repeat (17) begin
      wait_valid();
      step(1'b0, 1'($urandom_range(0, 1)), $urandom);
    end
    chk("instret_wrap", {28'b0, instret}, 32'd1);

    // randomised traffic
    repeat (600) begin
      reset = ($urandom_range(0, 59) == 0);
      lat   = $urandom_range(1, 4);
      if (!m_out && !mem_pend && $urandom_range(0, 19) == 0) begin
        spur = 1; spur_data = $urandom;
      end
      step(1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 1)), $urandom);
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
